// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hold/flush sequencing controller for the 5-stage pipeline
//
// Generates the hold and flush controls for the PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB registers. It handles load-use stalls, EX-stage redirects,
// multi-cycle dmem waits and the timeout of hung dmem accesses.
//
// Optional build macro: PIPE_PERF_CNT_EN adds the stall_cnt, flush_cnt and
// mem_timeout_cnt performance counter outputs.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   id_rs1/id_rs2              source registers of the instruction in ID
//   id_use_rs1/id_use_rs2      ID instruction actually reads rs1/rs2
//   ex_readMem, ex_rd          load type and destination of the instruction in EX
//   ex_redirect                taken branch or resolved jump in EX
//   mem_req, mem_ack           dmem access outstanding / completing this cycle
//   pc_hold .. memwb_flush     per-register hold and bubble controls
//   mem_err                    one-cycle pulse when a dmem access is aborted
//   state_o                    current FSM state (0 RUN, 1 MEM_WAIT, 2 REDIRECT)
//   stall_cnt, flush_cnt,
//   mem_timeout_cnt            performance counters (PIPE_PERF_CNT_EN only)

module pipe_hazard_ctrl #(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [2:0]  ex_readMem,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_hold,
    output logic        idex_flush,
    output logic        exmem_hold,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        mem_err,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [15:0] mem_timeout_cnt,
`endif
    output logic [1:0]  state_o
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    logic [1:0] r_state;
    logic [6:0] r_wait_cnt;
    logic [2:0] r_bub_cnt;

    logic       w_memstall;
    logic       w_loaduse;
    logic       w_abort;

    assign w_memstall = mem_req & ~mem_ack;

    // x0 is never a real dependency, so a load to x0 must not stall.
    assign w_loaduse = (ex_readMem != 3'd0) && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

    // Abort on the MEM_TIMEOUT-th consecutive unacked cycle; the counter
    // holds the number of unacked cycles already seen.
    assign w_abort = (MEM_TIMEOUT != 0) && w_memstall &&
                     ((32'(r_wait_cnt) + 32'd1) == MEM_TIMEOUT);

    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_hold   = 1'b0;
        idex_flush  = 1'b0;
        exmem_hold  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        mem_err     = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (w_abort) begin
            mem_err     = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (w_memstall) begin
            // Freeze everything up to EX/MEM; redirect and load-use in EX
            // stay visible and are acted on once the access completes.
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_hold  = 1'b1;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            // Any load-use against the ID instruction is wrong-path.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (w_loaduse) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_flush  = 1'b1;
        end else if (r_state == ST_REDIRECT) begin
            ifid_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 7'd0;
            r_bub_cnt  <= 3'd0;
        end else if (w_abort) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 7'd0;
        end else if (w_memstall) begin
            r_state <= ST_MEM_WAIT;
            if (r_wait_cnt != 7'h7f) begin
                r_wait_cnt <= r_wait_cnt + 7'd1;
            end
        end else begin
            r_wait_cnt <= 7'd0;
            if (ex_redirect) begin
                // Bubbles cover the imem latency of the redirected fetch.
                if (REDIRECT_BUBBLES != 0) begin
                    r_state   <= ST_REDIRECT;
                    r_bub_cnt <= 3'(REDIRECT_BUBBLES);
                end else begin
                    r_state <= ST_RUN;
                end
            end else if (r_state == ST_REDIRECT) begin
                r_bub_cnt <= r_bub_cnt - 3'd1;
                if (r_bub_cnt <= 3'd1) begin
                    r_state <= ST_RUN;
                end
            end else begin
                r_state <= ST_RUN;
            end
        end
    end

    assign state_o = r_state;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [15:0] r_mem_timeout_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt       <= 32'd0;
            r_flush_cnt       <= 32'd0;
            r_mem_timeout_cnt <= 16'd0;
        end else begin
            if (pc_hold) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (ex_redirect) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (mem_err) begin
                r_mem_timeout_cnt <= r_mem_timeout_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt       = r_stall_cnt;
    assign flush_cnt       = r_flush_cnt;
    assign mem_timeout_cnt = r_mem_timeout_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [2:0]  ex_readMem;
    logic        ex_redirect, mem_req, mem_ack;
    logic        pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush;
    logic        exmem_hold, exmem_flush, memwb_flush, mem_err;
    logic [1:0]  state_o;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [15:0] mem_timeout_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [10:0] sb_q[$];

    // Control vector order: pc_hold ifid_hold ifid_flush idex_hold idex_flush
    //                       exmem_hold exmem_flush memwb_flush mem_err
    localparam logic [8:0] C_NONE  = 9'b000000000;
    localparam logic [8:0] C_RST   = 9'b001010110;
    localparam logic [8:0] C_LU    = 9'b110010000;
    localparam logic [8:0] C_RED   = 9'b001010000;
    localparam logic [8:0] C_BUB   = 9'b001000000;
    localparam logic [8:0] C_STALL = 9'b110101010;
    localparam logic [8:0] C_ABORT = 9'b000000111;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REDIRECT_BUBBLES(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_readMem(ex_readMem), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_hold(idex_hold), .idex_flush(idex_flush),
        .exmem_hold(exmem_hold), .exmem_flush(exmem_flush),
        .memwb_flush(memwb_flush), .mem_err(mem_err),
`ifdef PIPE_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_timeout_cnt(mem_timeout_cnt),
`endif
        .state_o(state_o)
    );

    // Push the expectation for the inputs just driven, sample mid-cycle,
    // then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [8:0] ctl, input logic [1:0] st);
        logic [10:0] obs;
        logic [10:0] exp_v;
        sb_q.push_back({ctl, st});
        #4;
        obs = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush,
               exmem_hold, exmem_flush, memwb_flush, mem_err, state_o};
        exp_v = sb_q.pop_front();
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_readMem = 3'd0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
        @(posedge clk);
        #1;
        step("reset", C_RST, 2'd0);
        rst = 1'b0;
        step("idle", C_NONE, 2'd0);

        // load-use on rs2, then the bubble clears it
        ex_readMem = 3'b010; ex_rd = 5'd5; id_use_rs2 = 1'b1; id_rs2 = 5'd5;
        step("lu_rs2", C_LU, 2'd0);
        ex_readMem = 3'd0;
        step("lu_clear", C_NONE, 2'd0);
        // load-use on rs1
        id_use_rs2 = 1'b0; ex_readMem = 3'b001; ex_rd = 5'd9;
        id_use_rs1 = 1'b1; id_rs1 = 5'd9;
        step("lu_rs1", C_LU, 2'd0);
        // x0 destination and unused source never stall
        ex_readMem = 3'b010; ex_rd = 5'd0; id_rs1 = 5'd0;
        step("x0", C_NONE, 2'd0);
        ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
        step("no_use", C_NONE, 2'd0);
        ex_readMem = 3'd0; ex_rd = 5'd0; id_rs1 = 5'd0;

        // redirect with two bubbles
        ex_redirect = 1'b1;
        step("redir", C_RED, 2'd0);
        ex_redirect = 1'b0;
        step("redir_b1", C_BUB, 2'd2);
        step("redir_b2", C_BUB, 2'd2);
        step("redir_end", C_NONE, 2'd0);

        // a redirect inside REDIRECT reloads the bubble count
        ex_redirect = 1'b1;
        step("reld_0", C_RED, 2'd0);
        ex_redirect = 1'b0;
        step("reld_b1", C_BUB, 2'd2);
        ex_redirect = 1'b1;
        step("reld_again", C_RED, 2'd2);
        ex_redirect = 1'b0;
        step("reld_b2", C_BUB, 2'd2);
        step("reld_b3", C_BUB, 2'd2);
        step("reld_end", C_NONE, 2'd0);

        // plain memory wait: three unacked cycles then ack
        mem_req = 1'b1; mem_ack = 1'b0;
        step("mw_1", C_STALL, 2'd0);
        step("mw_2", C_STALL, 2'd1);
        step("mw_3", C_STALL, 2'd1);
        mem_ack = 1'b1;
        step("mw_ack", C_NONE, 2'd1);
        mem_req = 1'b0; mem_ack = 1'b0;
        step("mw_done", C_NONE, 2'd0);

        // redirect raised during the wait is acted on only at the ack
        mem_req = 1'b1;
        step("mwr_1", C_STALL, 2'd0);
        ex_redirect = 1'b1;
        step("mwr_2", C_STALL, 2'd1);
        step("mwr_3", C_STALL, 2'd1);
        mem_ack = 1'b1;
        step("mwr_ack", C_RED, 2'd1);
        mem_req = 1'b0; mem_ack = 1'b0; ex_redirect = 1'b0;
        step("mwr_b1", C_BUB, 2'd2);
        step("mwr_b2", C_BUB, 2'd2);
        step("mwr_end", C_NONE, 2'd0);

        // timeout: ack never arrives
        mem_req = 1'b1;
        step("to_1", C_STALL, 2'd0);
        step("to_2", C_STALL, 2'd1);
        step("to_3", C_STALL, 2'd1);
        step("to_abort", C_ABORT, 2'd1);
        step("to_restart", C_STALL, 2'd0);
        mem_req = 1'b0;
        step("to_drop", C_NONE, 2'd1);
        step("to_idle", C_NONE, 2'd0);

        // reset mid-wait clears the wait counter
        mem_req = 1'b1;
        step("rw_1", C_STALL, 2'd0);
        step("rw_2", C_STALL, 2'd1);
        rst = 1'b1;
        step("rw_rst1", C_RST, 2'd1);
        step("rw_rst2", C_RST, 2'd0);
        rst = 1'b0;
        step("rw_n1", C_STALL, 2'd0);
        step("rw_n2", C_STALL, 2'd1);
        step("rw_n3", C_STALL, 2'd1);
        step("rw_abort", C_ABORT, 2'd1);
        mem_req = 1'b0;
        step("rw_end", C_NONE, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage integer pipeline. It generates the hold and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use stalls, EX-stage control-flow redirects and multi-cycle data-memory waits, and it times out hung memory accesses. It replaces the per-register ad-hoc pause/flush wiring.

Parameters:
REDIRECT_BUBBLES, 1, extra cycles IF/ID is kept flushed after a redirect (covers imem latency); range 0-7
MEM_TIMEOUT, 64, max consecutive unacked dmem-wait cycles before abort; 0 = never time out

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
id_rs1  in  5  source reg 1 of instruction in ID
id_rs2  in  5  source reg 2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_readMem  in  3  load type of instruction in EX; nonzero = load
ex_rd  in  5  destination reg of instruction in EX
ex_redirect  in  1  branch taken / jump resolved in EX this cycle
mem_req  in  1  MEM stage has a dmem access outstanding
mem_ack  in  1  dmem completes the access this cycle
pc_hold  out  1  PC keeps its value
ifid_hold  out  1  IF/ID keeps contents
ifid_flush  out  1  IF/ID loads a bubble
idex_hold  out  1  ID/EX keeps contents (not cleared)
idex_flush  out  1  ID/EX loads a bubble
exmem_hold  out  1  EX/MEM keeps contents
exmem_flush  out  1  EX/MEM loads a bubble
memwb_flush  out  1  MEM/WB loads a bubble
mem_err  out  1  one-cycle pulse: dmem access aborted by timeout
state_o  out  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=0, MEM_WAIT=1, REDIRECT=2. Register wait_cnt (7 bits); register bub_cnt (3 bits).
- Control outputs are combinational from the current state and inputs. Registers update on posedge clk.
- rst=1: next state RUN, counters 0. While rst=1: ifid_flush=idex_flush=exmem_flush=memwb_flush=1, all holds 0, mem_err 0.
- Hazard terms:
  - memstall = mem_req & ~mem_ack
  - loaduse = (ex_readMem!=0) & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
- Priority, highest first: timeout abort > memstall > ex_redirect > loaduse > REDIRECT bubbles.
- memstall, not aborting:
  - pc_hold=ifid_hold=idex_hold=exmem_hold=1, memwb_flush=1.
  - ex_redirect and loaduse are ignored; EX is frozen, so both re-present after the wait.
  - State goes to MEM_WAIT; wait_cnt increments, saturating.
- Abort: MEM_TIMEOUT!=0 and memstall and wait_cnt+1==MEM_TIMEOUT (the MEM_TIMEOUT-th consecutive unacked cycle).
  - mem_err=1, exmem_flush=1, memwb_flush=1, all holds 0.
  - Next state RUN, wait_cnt 0.
- mem_ack=1 in MEM_WAIT: no holds that cycle; next state RUN, wait_cnt 0.
- ex_redirect:
  - ifid_flush=1, idex_flush=1, no holds; a pending loaduse is discarded as wrong-path.
  - If REDIRECT_BUBBLES>0: next state REDIRECT with bub_cnt=REDIRECT_BUBBLES.
- REDIRECT state: ifid_flush=1 each cycle and bub_cnt decrements; at bub_cnt==1, next state RUN.
  - A new ex_redirect here reloads bub_cnt.
  - A loaduse here is not possible (IF/ID holds a bubble); no special case.
- loaduse in RUN: pc_hold=1, ifid_hold=1, idex_flush=1, for exactly one cycle. The bubble clears the term; EX/MEM forwarding covers the rest.
- No hazard: all outputs 0.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined: adds outputs stall_cnt[31:0], flush_cnt[31:0], mem_timeout_cnt[15:0], all reset to 0 and wrapping.
  - stall_cnt counts cycles with pc_hold=1.
  - flush_cnt counts ex_redirect cycles.
  - mem_timeout_cnt counts mem_err pulses.
- Undefined: the ports and counters are absent; there is no other behavioural difference.

Test Plan:
- Load-use: ex_readMem=3'b010, ex_rd=5, id_use_rs2=1, id_rs2=5 -> one cycle of pc_hold=ifid_hold=idex_flush=1. Next cycle with ex_readMem=0 -> all outputs 0.
- x0 / no-use: ex_readMem=3'b010, ex_rd=0, id_rs1=0; then ex_rd=7, id_rs1=7, id_use_rs1=0 -> no stall in either case.
- Redirect, REDIRECT_BUBBLES=2: ex_redirect pulse -> ifid_flush for 3 consecutive cycles, idex_flush for the first only; state_o 0->2->2->0.
- Mem wait: mem_req=1, ack low 3 cycles then high -> holds=1 and memwb_flush=1 for 3 cycles; ack cycle has holds 0; state returns to RUN. Also raise ex_redirect during the wait -> ignored until the ack cycle.
- Timeout, MEM_TIMEOUT=4, ack never: cycles 1-3 hold; cycle 4 mem_err=1, exmem_flush=1, holds 0; cycle 5 state_o=0.
- Reset mid-wait: rst asserted in MEM_WAIT -> all four flush outputs 1 while rst=1; after release state_o=0, wait_cnt restarts (timeout needs a full 4 new cycles).
